// File: rtl/modexp_ctrl.sv
// rtl/modexp_ctrl.sv - left-to-right square-and-multiply sequencer for RSA modexp
//
// Computes result = base^exponent mod n by driving a shared Montgomery-domain
// conversion unit (x*R mod n) and a Montgomery multiplier (a*b*R^-1 mod n).
// The modulus is wired straight to both units and never passes through here.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   start               request pulse, only looked at while idle
//   base, exponent      operands, latched when a start is accepted
//   exp_len             index of the highest exponent bit to process
//   busy, done          busy while a job runs; done pulses once with result
//   result              plain-domain result, held until the next done
//   conv_start, conv_x  conversion launch pulse and operand
//   conv_finish         conversion level status; conv_result valid while high
//   mm_start, mm_a/b    multiply launch pulse and operands
//   mm_done, mm_result  multiply completion pulse and product
module modexp_ctrl #(
  parameter int WIDTH = 2048,
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [LEN_W-1:0] exp_len,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             conv_start,
  output logic [WIDTH-1:0] conv_x,
  input  logic             conv_finish,
  input  logic [WIDTH-1:0] conv_result,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  input  logic             mm_done,
  input  logic [WIDTH-1:0] mm_result
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CONV_B    = 4'd1,
    S_WAIT_CB   = 4'd2,
    S_CONV_ONE  = 4'd3,
    S_WAIT_C1   = 4'd4,
    S_SQR       = 4'd5,
    S_WAIT_SQR  = 4'd6,
    S_MUL       = 4'd7,
    S_WAIT_MUL  = 4'd8,
    S_NEXT      = 4'd9,
    S_EXIT      = 4'd10,
    S_WAIT_EXIT = 4'd11,
    S_DONE      = 4'd12
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             conv_fin_q;
  logic             conv_rise;

  // A level left high by an earlier conversion must not look like completion,
  // so only a low-to-high transition counts.
  assign conv_rise = conv_finish & ~conv_fin_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      e_q        <= '0;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      conv_fin_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      e_q        <= e_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      conv_fin_q <= conv_finish;
    end
  end

  // Operands are decoded from the state so they stay constant from the launch
  // pulse through the whole wait; A only changes on the edge leaving a wait.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    e_d        = e_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    conv_start = 1'b0;
    conv_x     = '0;
    mm_start   = 1'b0;
    mm_a       = '0;
    mm_b       = '0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base;
          e_d     = exponent;
          idx_d   = exp_len;
          state_d = S_CONV_B;
        end
      end
      S_CONV_B: begin
        conv_x     = base_q;
        conv_start = 1'b1;
        state_d    = S_WAIT_CB;
      end
      S_WAIT_CB: begin
        conv_x = base_q;
        if (conv_rise) begin
          b_d     = conv_result;
          state_d = S_CONV_ONE;
        end
      end
      S_CONV_ONE: begin
        conv_x     = ONE;
        conv_start = 1'b1;
        state_d    = S_WAIT_C1;
      end
      S_WAIT_C1: begin
        conv_x = ONE;
        // Converting 1 yields R mod n, the Montgomery form of 1.
        if (conv_rise) begin
          a_d     = conv_result;
          state_d = S_SQR;
        end
      end
      S_SQR: begin
        mm_a     = a_q;
        mm_b     = a_q;
        mm_start = 1'b1;
        state_d  = S_WAIT_SQR;
      end
      S_WAIT_SQR: begin
        mm_a = a_q;
        mm_b = a_q;
        if (mm_done) begin
          a_d     = mm_result;
          state_d = e_q[idx_q] ? S_MUL : S_NEXT;
        end
      end
      S_MUL: begin
        mm_a     = a_q;
        mm_b     = b_q;
        mm_start = 1'b1;
        state_d  = S_WAIT_MUL;
      end
      S_WAIT_MUL: begin
        mm_a = a_q;
        mm_b = b_q;
        if (mm_done) begin
          a_d     = mm_result;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx_q == '0) begin
          state_d = S_EXIT;
        end else begin
          idx_d   = idx_q - LEN_W'(1);
          state_d = S_SQR;
        end
      end
      S_EXIT: begin
        // Multiplying by plain 1 strips the R factor out of the accumulator.
        mm_a     = a_q;
        mm_b     = ONE;
        mm_start = 1'b1;
        state_d  = S_WAIT_EXIT;
      end
      S_WAIT_EXIT: begin
        mm_a = a_q;
        mm_b = ONE;
        if (mm_done) begin
          result_d = mm_result;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// tb/tb_modexp_ctrl.sv - self-checking bench for modexp_ctrl with behavioural unit models
//
// No ports. Runs modexp_ctrl at WIDTH=16, n=497 against behavioural conversion
// and Montgomery multiplier models; expected results come from a plain
// square-and-multiply reference pushed to a scoreboard at each start.
module tb_modexp_ctrl;

  localparam int WIDTH = 16;
  localparam int LEN_W = 4;
  localparam longint N = 497;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] base = '0;
  logic [WIDTH-1:0] exponent = '0;
  logic [LEN_W-1:0] exp_len = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             conv_start;
  logic [WIDTH-1:0] conv_x;
  logic             conv_finish = 1'b0;
  logic [WIDTH-1:0] conv_result = '0;
  logic             mm_start;
  logic [WIDTH-1:0] mm_a;
  logic [WIDTH-1:0] mm_b;
  logic             mm_done = 1'b0;
  logic [WIDTH-1:0] mm_result = '0;

  modexp_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .exponent(exponent),
    .exp_len(exp_len), .busy(busy), .done(done), .result(result),
    .conv_start(conv_start), .conv_x(conv_x), .conv_finish(conv_finish),
    .conv_result(conv_result), .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b),
    .mm_done(mm_done), .mm_result(mm_result)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_conv = 0;
  int n_mm = 0;
  int n_done = 0;
  int op_err = 0;
  int conv0 = 0;
  int mm0 = 0;
  int done0 = 0;
  int stale_hold = 0;

  int exp_res_q[$];
  int exp_mm_q[$];

  function automatic longint mont(longint a, longint b);
    longint t;
    t = a * b;
    for (int i = 0; i < WIDTH; i++) begin
      if (t[0]) t = t + N;
      t = t >> 1;
    end
    if (t >= N) t = t - N;
    return t;
  endfunction

  function automatic int ref_modexp(int b, int e, int len);
    longint r;
    r = 1;
    for (int i = len; i >= 0; i--) begin
      r = (r * r) % N;
      if (((e >> i) & 1) == 1) r = (r * longint'(b)) % N;
    end
    return int'(r);
  endfunction

  function automatic int ref_mm_count(int e, int len);
    int c;
    c = len + 2;
    for (int i = 0; i <= len; i++) c = c + ((e >> i) & 1);
    return c;
  endfunction

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (conv_start === 1'b1) n_conv++;
      if (mm_start === 1'b1) n_mm++;
      if (done === 1'b1) n_done++;
    end
  end

  // Conversion unit: optional stale-high period carrying garbage, then low,
  // then high with x*R mod n.
  int c_hold = 0;
  int c_cnt = 0;
  bit c_busy = 1'b0;
  logic [WIDTH-1:0] c_x = '0;
  always @(negedge clk) begin
    if (conv_start === 1'b1) begin
      c_x = conv_x;
      c_hold = stale_hold;
      c_cnt = 3;
      c_busy = 1'b1;
      if (stale_hold == 0) conv_finish = 1'b0;
      else conv_result = 16'h1234;
    end else if (c_busy) begin
      if (c_hold > 0) begin
        c_hold--;
        if (c_hold == 0) conv_finish = 1'b0;
      end else begin
        c_cnt--;
        if (c_cnt == 0) begin
          if (busy === 1'b1 && conv_x !== c_x) op_err++;
          conv_result = WIDTH'((longint'(c_x) << WIDTH) % N);
          conv_finish = 1'b1;
          c_busy = 1'b0;
        end
      end
    end
  end

  // Montgomery multiplier: random 2..5 cycle latency, one-cycle done pulse.
  int m_cnt = 0;
  bit m_busy = 1'b0;
  logic [WIDTH-1:0] m_a = '0;
  logic [WIDTH-1:0] m_b = '0;
  always @(negedge clk) begin
    mm_done = 1'b0;
    if (mm_start === 1'b1) begin
      m_a = mm_a;
      m_b = mm_b;
      m_cnt = int'($urandom_range(2, 5));
      m_busy = 1'b1;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        if (busy === 1'b1 && (mm_a !== m_a || mm_b !== m_b)) op_err++;
        mm_result = WIDTH'(mont(longint'(m_a), longint'(m_b)));
        mm_done = 1'b1;
        m_busy = 1'b0;
      end
    end
  end

  // Called at a negedge; returns at the negedge of the first busy cycle.
  task automatic start_job(input int b, input int e, input int len);
    base = WIDTH'(b);
    exponent = WIDTH'(e);
    exp_len = LEN_W'(len);
    start = 1'b1;
    exp_res_q.push_back(ref_modexp(b, e, len));
    exp_mm_q.push_back(ref_mm_count(e, len));
    conv0 = n_conv;
    mm0 = n_mm;
    done0 = n_done;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge one cycle after done (the controller is idle again).
  task automatic wait_done(output bit ok, output logic [WIDTH-1:0] res,
                           output int dconv, output int dmm, output int ddone);
    ok = 1'b0;
    res = 'x;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        res = result;
        break;
      end
    end
    @(negedge clk);
    dconv = n_conv - conv0;
    dmm = n_mm - mm0;
    ddone = n_done - done0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    tests++; if (conv_start !== 1'b0 || mm_start !== 1'b0) begin fails++; $display("FAIL reset_starts got=%b%b exp=00", conv_start, mm_start); end
    tests++; if (result !== '0 || conv_x !== '0 || mm_a !== '0 || mm_b !== '0) begin fails++; $display("FAIL reset_data got=%0d/%0d/%0d/%0d exp=0", result, conv_x, mm_a, mm_b); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok; logic [WIDTH-1:0] res; int dc, dm, dd, er, em;
    start_job(4, 13, 3);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got=%b exp=1", busy); end
    wait_done(ok, res, dc, dm, dd);
    er = exp_res_q.pop_front(); em = exp_mm_q.pop_front();
    tests++; if (!ok) begin fails++; $display("FAIL basic_timeout got=no_done exp=done"); end
    tests++; if (res !== 16'd445 || res !== WIDTH'(er)) begin fails++; $display("FAIL basic_result got=%0d exp=%0d", res, er); end
    tests++; if (dc !== 2) begin fails++; $display("FAIL basic_conv_pulses got=%0d exp=2", dc); end
    tests++; if (dm !== em || dm !== 8) begin fails++; $display("FAIL basic_mm_pulses got=%0d exp=%0d", dm, em); end
    tests++; if (dd !== 1) begin fails++; $display("FAIL basic_done_pulses got=%0d exp=1", dd); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_zero_exp();
    bit ok; logic [WIDTH-1:0] res; int dc, dm, dd, er, em;
    start_job(7, 0, 0);
    wait_done(ok, res, dc, dm, dd);
    er = exp_res_q.pop_front(); em = exp_mm_q.pop_front();
    tests++; if (!ok || res !== WIDTH'(er) || res !== 16'd1) begin fails++; $display("FAIL zero_exp_result got=%0d exp=%0d", res, er); end
    tests++; if (dm !== em || dm !== 2) begin fails++; $display("FAIL zero_exp_mm_pulses got=%0d exp=%0d", dm, em); end
    tests++; if (dc !== 2 || dd !== 1) begin fails++; $display("FAIL zero_exp_counts got=%0d/%0d exp=2/1", dc, dd); end
  endtask

  task automatic test_start_ignored();
    bit ok; logic [WIDTH-1:0] res; int dc, dm, dd, er, em, d_before;
    start_job(4, 13, 3);
    @(negedge clk);
    base = 16'd9; exponent = 16'd7; exp_len = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok, res, dc, dm, dd);
    er = exp_res_q.pop_front(); em = exp_mm_q.pop_front();
    tests++; if (!ok || res !== WIDTH'(er)) begin fails++; $display("FAIL ignored_result got=%0d exp=%0d", res, er); end
    tests++; if (dm !== em || dc !== 2) begin fails++; $display("FAIL ignored_pulses got=%0d/%0d exp=%0d/2", dm, dc, em); end
    d_before = n_done;
    repeat (80) @(negedge clk);
    tests++; if (n_done !== d_before || busy !== 1'b0) begin fails++; $display("FAIL ignored_second_done got=%0d busy=%b exp=%0d busy=0", n_done, busy, d_before); end
  endtask

  task automatic test_reset_mid();
    bit ok, seen; logic [WIDTH-1:0] res; int dc, dm, dd, er, em, d_before;
    start_job(4, 13, 3);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (mm_start === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    tests++; if (!seen) begin fails++; $display("FAIL rstmid_no_square got=no_mm_start exp=mm_start"); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin fails++; $display("FAIL rstmid_outputs got=busy%b done%b res%0d exp=0/0/0", busy, done, result); end
    void'(exp_res_q.pop_front()); void'(exp_mm_q.pop_front());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    d_before = n_done;
    repeat (20) @(negedge clk);
    tests++; if (busy !== 1'b0 || result !== '0 || n_done !== d_before) begin fails++; $display("FAIL rstmid_late_done got=busy%b res%0d done%0d exp=0/0/%0d", busy, result, n_done, d_before); end
    start_job(4, 13, 3);
    wait_done(ok, res, dc, dm, dd);
    er = exp_res_q.pop_front(); em = exp_mm_q.pop_front();
    tests++; if (!ok || res !== WIDTH'(er)) begin fails++; $display("FAIL rstmid_rerun_result got=%0d exp=%0d", res, er); end
    tests++; if (dc !== 2 || dm !== em || dd !== 1) begin fails++; $display("FAIL rstmid_rerun_pulses got=%0d/%0d/%0d exp=2/%0d/1", dc, dm, dd, em); end
  endtask

  task automatic test_stale_conv();
    bit ok; logic [WIDTH-1:0] res; int dc, dm, dd, er, em;
    tests++; if (conv_finish !== 1'b1) begin fails++; $display("FAIL stale_precondition got=%b exp=1", conv_finish); end
    stale_hold = 2;
    start_job(5, 11, 3);
    wait_done(ok, res, dc, dm, dd);
    stale_hold = 0;
    er = exp_res_q.pop_front(); em = exp_mm_q.pop_front();
    tests++; if (!ok || res !== WIDTH'(er)) begin fails++; $display("FAIL stale_result got=%0d exp=%0d", res, er); end
    tests++; if (dc !== 2 || dm !== em || dd !== 1) begin fails++; $display("FAIL stale_pulses got=%0d/%0d/%0d exp=2/%0d/1", dc, dm, dd, em); end
  endtask

  task automatic test_back_to_back();
    bit ok; logic [WIDTH-1:0] res; int dc, dm, dd, er, em;
    start_job(4, 13, 3);
    wait_done(ok, res, dc, dm, dd);
    er = exp_res_q.pop_front(); em = exp_mm_q.pop_front();
    tests++; if (!ok || res !== WIDTH'(er)) begin fails++; $display("FAIL b2b_first_result got=%0d exp=%0d", res, er); end
    start_job(3, 5, 2);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    wait_done(ok, res, dc, dm, dd);
    er = exp_res_q.pop_front(); em = exp_mm_q.pop_front();
    tests++; if (!ok || res !== WIDTH'(er) || res !== 16'd243) begin fails++; $display("FAIL b2b_second_result got=%0d exp=%0d", res, er); end
    tests++; if (dc !== 2 || dm !== em || dd !== 1) begin fails++; $display("FAIL b2b_pulses got=%0d/%0d/%0d exp=2/%0d/1", dc, dm, dd, em); end
    tests++; if (op_err !== 0) begin fails++; $display("FAIL operand_stability got=%0d exp=0", op_err); end
    tests++; if (exp_res_q.size() !== 0) begin fails++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_res_q.size()); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero_exp();
    test_start_ignored();
    test_reset_mid();
    test_stale_conv();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
